mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one combinational multiplier (`mult` instance, WIDTH bits) between NUM_REQ requesters.
- Each requester uses a valid/ready handshake; the arbiter picks one winner per cycle by round-robin.
- The winner's operands are registered into the multiplier inputs, and the product returns one cycle later on a shared result bus with a one-hot response strobe.
- Sits between the input shift registers and the multiplier in size-exploration tops that time-multiplex one datapath.

Parameters:
- WIDTH, 6, operand width in bits; product is 2*WIDTH.
- NUM_REQ, 4, number of requesters, 2..8.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; low blocks new grants
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  one-hot grant; handshake = valid & ready
- req_a  input  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand B, same packing
- mul_a  output  WIDTH  registered operand A to multiplier
- mul_b  output  WIDTH  registered operand B to multiplier
- mul_out  input  2*WIDTH  multiplier product (combinational from mul_a/mul_b)
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe
- rsp_data  output  2*WIDTH  registered product, valid when rsp_valid != 0
- busy  output  1  high while any operation is in flight

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n), fixed.
- Reset values:
  - mul_a, mul_b, rsp_data = 0; rsp_valid = 0; busy = 0.
  - Internal stage-1 valid = 0; tag = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority after reset.
- Grant:
  - req_ready is combinational from req_valid, the pointer and ena.
  - Search starts at pointer+1 mod NUM_REQ; the first asserted req_valid wins.
  - req_ready is all-zero if ena=0 or no valid.
  - At most one bit is set. Ready never asserts without the matching valid.
- Handshake at edge t:
  - mul_a/mul_b <= winner's operands; tag <= winner index; s1_valid <= 1; pointer <= winner index.
  - No handshake: s1_valid <= 0, and mul_a/mul_b/tag hold their values (no toggling).
- Response at edge t+1, if s1_valid: rsp_data <= mul_out; rsp_valid <= one-hot(tag).
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Total latency is 2 edges from handshake to strobe visible.
- Throughput: one product per cycle; back-to-back grants are allowed, including to the same requester when it is the only one valid.
- No response backpressure: requesters must sink rsp_valid in the strobe cycle.
- ena:
  - Gates only new grants.
  - In-flight operations complete even if ena drops.
  - ena low never corrupts the pointer.
- busy = s1_valid | (rsp_valid != 0).
- Width rules:
  - Unsigned operands; the product is exactly 2*WIDTH, no truncation.
  - Pointer is clog2(NUM_REQ) bits, with explicit wrap at NUM_REQ-1 -> 0 for non-power-of-two NUM_REQ.
- Reset mid-operation:
  - In-flight ops are discarded and no rsp_valid is emitted.
  - The pointer returns to NUM_REQ-1.
- Requester dropping valid without a grant is legal; there is no penalty and its priority is unchanged.

Decomposition:
- Shared package `size_expl_pkg`:
  - localparam-style constants for default WIDTH/NUM_REQ.
  - Function `rr_pick(valid, ptr)` returning {found, index}.
  - Function `onehot(idx)`.
- One natural sub-module, `rr_arbiter`:
  - Pointer register plus combinational pick, parameterised by NUM_REQ.
  - Reused by future shared-FMA/adder variants.
- The multiplier itself stays outside.

Test Plan:
1. Reset, then req_valid=4'b0001 with a=5, b=7, ena=1, held 1 cycle -> req_ready=0001 that cycle; mul_a=5, mul_b=7 next cycle; rsp_valid=0001 with rsp_data=35 the cycle after; busy high for exactly 2 cycles.
2. All four valid continuously, a=i+1, b=63 -> grants rotate 0,1,2,3,0; rsp_data sequence 63,126,189,252,63 with one-hot strobes matching; one response per cycle.
3. Only requester 2 valid for 3 cycles with a=63, b=63 -> three consecutive grants to 2; three rsp_data=3969 (max, no truncation); pointer then 2, so the next all-valid contention grants 3 first.
4. ena dropped the cycle after a grant, with requesters still valid -> req_ready=0 while ena=0; the in-flight product still appears on schedule; on ena=1, the grant resumes at pointer+1.
5. rst_n asserted asynchronously mid-cycle with one op in stage 1 -> outputs zero immediately; no rsp_valid afterwards; after release, requester 0 wins first under full contention.
6. NUM_REQ=3, all valid -> grants 0,1,2,0 (wrap without index 3); a lone req_valid=3'b100 granted -> rsp_valid=100.

Source files
------------

// File: rtl/size_expl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : size_expl_pkg
// Description : Shared constants and helpers for the size-exploration tops
//               that time-multiplex one datapath between several requesters.
//               - DEF_WIDTH / DEF_NUM_REQ : default operand width / requesters
//               - rr_pick(valid, ptr, n)  : round-robin search, {found, index}
//               - onehot(idx)             : index to one-hot vector
// Revision    : 1.0  initial release
// ============================================================================
package size_expl_pkg;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_NUM_REQ = 4;
    // Helpers are written for the largest supported requester count; callers
    // zero-extend narrower vectors into these widths.
    localparam int MAX_REQ     = 8;
    localparam int MAX_IDX_W   = 3;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // Search starts one past ptr and wraps explicitly at num_req-1 -> 0, so
    // non-power-of-two requester counts never visit an unused index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int unsigned          num_req);
        pick_t                res;
        logic [MAX_IDX_W-1:0] idx;
        res = '0;
        idx = ptr;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < int'(num_req)) begin
                idx = (idx == MAX_IDX_W'(num_req - 1)) ? '0 : idx + 1'b1;
                if (!res.found && valid[idx]) begin
                    res.found = 1'b1;
                    res.idx   = idx;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin pointer register plus combinational pick. The
//               pointer records the last winner; it only moves on a grant.
// Ports       : clk, rst_n     clock, asynchronous active-low reset
//               ena            low suppresses all grants (pointer untouched)
//               valid          per-requester request
//               grant          one-hot grant (subset of valid)
//               grant_idx      index of the winner (meaningful with grant_vld)
//               grant_vld      a grant is issued this cycle
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import size_expl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic [MAX_REQ-1:0]   valid_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    logic [MAX_REQ-1:0]   grant_oh;
    pick_t                pick;
    logic                 unused_pick;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = valid;
        ptr_ext                  = '0;
        ptr_ext[IDX_W-1:0]       = ptr_q;
        pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
        grant_vld                = ena & pick.found;
        grant_idx                = pick.idx[IDX_W-1:0];
        grant_oh                 = onehot(pick.idx);
        grant                    = grant_vld ? grant_oh[NUM_REQ-1:0] : '0;
        ptr_d                    = grant_vld ? grant_idx : ptr_q;
    end

    // Upper helper bits are zero by construction for small NUM_REQ.
    assign unused_pick = ^{pick, grant_oh};

    // Reset value makes requester 0 the first candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Shares one external combinational multiplier between NUM_REQ
//               valid/ready requesters. Winner operands are registered onto
//               mul_a/mul_b; the product is registered one edge later and
//               returned with a one-hot strobe naming the requester.
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               ena                 low blocks new grants only
//               req_valid/req_ready per-requester handshake (ready one-hot)
//               req_a/req_b         packed operands, requester i at [i*W +: W]
//               mul_a/mul_b         registered operands to the multiplier
//               mul_out             multiplier product
//               rsp_valid/rsp_data  one-hot strobe and registered product
//               busy                an operation is in flight
// Revision    : 1.0  initial release
// ============================================================================
module mult_share_arbiter
    import size_expl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_data,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [WIDTH-1:0]     a_arr [NUM_REQ];
    logic [WIDTH-1:0]     b_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_vld;

    logic [WIDTH-1:0]     mul_a_q,     mul_a_d;
    logic [WIDTH-1:0]     mul_b_q,     mul_b_d;
    logic [IDX_W-1:0]     tag_q,       tag_d;
    logic                 s1_valid_q,  s1_valid_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]   rsp_data_q,  rsp_data_d;

    logic [MAX_IDX_W-1:0] tag_ext;
    logic [MAX_REQ-1:0]   tag_oh;
    logic                 unused_tag_oh;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
            assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // Stage 1: operands and tag hold when idle so the multiplier inputs do
    // not toggle without a handshake.
    always_comb begin
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        tag_d      = tag_q;
        s1_valid_d = 1'b0;
        if (grant_vld) begin
            mul_a_d    = a_arr[grant_idx];
            mul_b_d    = b_arr[grant_idx];
            tag_d      = grant_idx;
            s1_valid_d = 1'b1;
        end
    end

    // Stage 2: capture the product; the data bus holds between strobes.
    always_comb begin
        tag_ext            = '0;
        tag_ext[IDX_W-1:0] = tag_q;
        tag_oh             = onehot(tag_ext);
        rsp_valid_d        = '0;
        rsp_data_d         = rsp_data_q;
        if (s1_valid_q) begin
            rsp_valid_d = tag_oh[NUM_REQ-1:0];
            rsp_data_d  = mul_out;
        end
    end

    assign unused_tag_oh = ^tag_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_q       <= '0;
            s1_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_q       <= tag_d;
            s1_valid_q  <= s1_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = grant;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = s1_valid_q | (|rsp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter. A 4-requester
//               instance is compared every cycle against a transaction-level
//               reference model; a 3-requester instance checks wrap-around.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int W = 6;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [W-1:0]     mul_a, mul_b;
    logic [2*W-1:0]   mul_out;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_data;
    logic             busy;

    logic [2:0]       v3 = '0;
    logic [2:0]       rdy3, rv3;
    logic [3*W-1:0]   a3 = '0, b3 = '0;
    logic [W-1:0]     ma3, mb3;
    logic [2*W-1:0]   mo3, rd3;
    logic             busy3;

    always #5 clk = ~clk;

    // External multiplier stand-ins.
    assign mul_out = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
    assign mo3     = {{W{1'b0}}, ma3} * {{W{1'b0}}, mb3};

    mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    mult_share_arbiter #(.WIDTH(W), .NUM_REQ(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1),
        .req_valid(v3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3),
        .mul_a(ma3), .mul_b(mb3), .mul_out(mo3),
        .rsp_valid(rv3), .rsp_data(rd3), .busy(busy3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int m_last;              // last granted requester
    bit m_inflight;          // an accepted operation awaits its product
    int m_who;               // requester owning the in-flight operation
    int m_opa, m_opb;        // operands currently presented to the multiplier
    int m_rsp_to;            // requester strobed this cycle, -1 if none
    int m_rsp_val;           // product currently on the result bus
    int m_win;

    function automatic int rr_winner(input logic [N-1:0] v, input int last, input bit en);
        if (!en) return -1;
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1; m_inflight = 0; m_who = 0;
        m_opa = 0; m_opb = 0; m_rsp_to = -1; m_rsp_val = 0;
    endtask

    function automatic logic [31:0] bit_of(input int idx);
        return (idx < 0) ? 32'd0 : (32'd1 << idx);
    endfunction

    // One clock: check the grant, advance through the edge, check outputs.
    task automatic cycle();
        #1;
        m_win = rr_winner(req_valid, m_last, ena);
        chk("req_ready", 32'(req_ready), bit_of(m_win));
        @(posedge clk);
        if (m_inflight) begin
            m_rsp_to  = m_who;
            m_rsp_val = m_opa * m_opb;
        end else begin
            m_rsp_to = -1;
        end
        if (m_win >= 0) begin
            m_opa = int'(req_a[m_win*W +: W]);
            m_opb = int'(req_b[m_win*W +: W]);
            m_who = m_win;
            m_last = m_win;
            m_inflight = 1;
        end else begin
            m_inflight = 0;
        end
        #1;
        chk("mul_a",     32'(mul_a),     32'(m_opa));
        chk("mul_b",     32'(mul_b),     32'(m_opb));
        chk("rsp_valid", 32'(rsp_valid), bit_of(m_rsp_to));
        chk("rsp_data",  32'(rsp_data),  32'(m_rsp_val));
        chk("busy",      32'(busy),      32'(m_inflight || m_rsp_to >= 0));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #4 rst_n = 1'b1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 0);
        #4 rst_n = 1'b1;

        // 1: single operation 5*7
        ena = 1'b1;
        set_ops(0, 5, 7);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        chk("t1_rsp_data", 32'(rsp_data), 35);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        cycle();
        cycle();

        // 2: full contention rotates 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, i + 1, 63);
        req_valid = '1;
        for (int c = 0; c < 5; c++) cycle();
        req_valid = '0;
        cycle();
        cycle();

        // 3: lone requester 2 at max operands, then contention grants 3
        req_valid = 4'b0100;
        set_ops(2, 63, 63);
        for (int c = 0; c < 3; c++) cycle();
        chk("t3_max", 32'(rsp_data), 3969);
        req_valid = '1;
        #1 chk("t3_next_grant", 32'(req_ready), 32'b1000);
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        // 4: ena drops after a grant
        req_valid = '1;
        cycle();
        ena = 1'b0;
        cycle();
        cycle();
        ena = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        // 5: asynchronous reset with an operation in stage 1
        req_valid = '1;
        set_ops(1, 33, 44);
        cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_mul_a",     32'(mul_a), 0);
        chk("t5_mul_b",     32'(mul_b), 0);
        chk("t5_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_rsp_data",  32'(rsp_data), 0);
        chk("t5_busy",      32'(busy), 0);
        @(posedge clk);
        #1 chk("t5_no_rsp", 32'(rsp_valid), 0);
        #3 rst_n = 1'b1;
        #1 chk("t5_first", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = '0;
        cycle();
        cycle();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            ena = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) set_ops(i, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            cycle();
        end
        req_valid = '0;
        ena = 1'b1;
        cycle();
        cycle();

        // 6: three requesters wrap 0,1,2,0 then lone requester 2
        a3[2*W +: W] = W'(9);
        b3[2*W +: W] = W'(11);
        v3 = 3'b111;
        #1 chk("n3_g0", 32'(rdy3), 32'b001);
        @(posedge clk); #1 chk("n3_g1", 32'(rdy3), 32'b010);
        @(posedge clk); #1 chk("n3_g2", 32'(rdy3), 32'b100);
        @(posedge clk); #1 chk("n3_g3", 32'(rdy3), 32'b001);
        @(posedge clk); #1;
        v3 = 3'b100;
        #1 chk("n3_lone", 32'(rdy3), 32'b100);
        @(posedge clk); #1;
        v3 = '0;
        @(posedge clk); #1;
        chk("n3_rsp_valid", 32'(rv3), 32'b100);
        chk("n3_rsp_data", 32'(rd3), 99);
        @(posedge clk); #1;
        chk("n3_idle", 32'(busy3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
